// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency synchronous ROM
// between the instruction-fetch (IF) and load/debug (LS) read requesters.
module rom_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  localparam logic IdIf = 1'b0;
  localparam logic IdLs = 1'b1;

  logic last_gnt_q, last_gnt_d;
  logic pend_v_q, pend_v_d;
  logic pend_id_q, pend_id_d;
  logic gnt_v;
  logic gnt_id;

  // Ties go to whichever requester was not granted last.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = IdIf;
    if (!reset) begin
      if (if_req && ls_req) begin
        gnt_v  = 1'b1;
        gnt_id = ~last_gnt_q;
      end else if (if_req) begin
        gnt_v  = 1'b1;
        gnt_id = IdIf;
      end else if (ls_req) begin
        gnt_v  = 1'b1;
        gnt_id = IdLs;
      end
    end
  end

  always_comb begin
    if_gnt   = gnt_v && (gnt_id == IdIf);
    ls_gnt   = gnt_v && (gnt_id == IdLs);
    rom_addr = '0;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (ls_gnt) begin
      rom_addr = ls_addr;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    pend_v_d   = 1'b0;
    pend_id_d  = pend_id_q;
    if (gnt_v) begin
      last_gnt_d = gnt_id;
      pend_v_d   = 1'b1;
      pend_id_d  = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= IdLs;
      pend_v_q   <= 1'b0;
      pend_id_q  <= IdIf;
    end else begin
      last_gnt_q <= last_gnt_d;
      pend_v_q   <= pend_v_d;
      pend_id_q  <= pend_id_d;
    end
  end

  // Responses are masked while reset is held so nothing leaks out mid-reset.
  always_comb begin
    if_rvalid = !reset && pend_v_q && (pend_id_q == IdIf);
    ls_rvalid = !reset && pend_v_q && (pend_id_q == IdLs);
    if_rdata  = if_rvalid ? rom_dout : '0;
    ls_rdata  = ls_rvalid ? rom_dout : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural 1-cycle-latency ROM.
module tb_rom_arbiter;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              if_req, ls_req;
  logic [ADDR_W-1:0] if_addr, ls_addr;
  logic              if_gnt, ls_gnt, if_rvalid, ls_rvalid;
  logic [DATA_W-1:0] if_rdata, ls_rdata;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;

  int checks;
  int failures;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_addr  (ls_addr),
    .ls_gnt   (ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    return 32'hC0DE0000 | {22'd0, a};
  endfunction

  initial rom_dout = '0;
  always @(posedge clk) rom_dout <= rom_val(rom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; if_addr = 10'd3; ls_addr = 10'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ctl cyc=%0d got=%b exp=0000", i,
                 {if_gnt, ls_gnt, if_rvalid, ls_rvalid});
      end
      checks++;
      if (rom_addr !== 10'd0 || if_rdata !== 32'd0 || ls_rdata !== 32'd0) begin
        failures++;
        $display("FAIL reset_data cyc=%0d addr=%0d ifd=%h lsd=%h exp=0", i, rom_addr,
                 if_rdata, ls_rdata);
      end
      step();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b10 || rom_addr !== 10'd3) begin
      failures++;
      $display("FAIL reset_first_tie got gnt=%b addr=%0d exp gnt=10 addr=3",
               {if_gnt, ls_gnt}, rom_addr);
    end
    step();
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== rom_val(10'd3) || ls_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_resp got v=%b d=%h lsv=%b exp v=1 d=%h lsv=0",
               if_rvalid, if_rdata, ls_rvalid, rom_val(10'd3));
    end
    step();
  endtask

  task automatic test_if_only();
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = ADDR_W'(i);
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || rom_addr !== ADDR_W'(i)) begin
        failures++;
        $display("FAIL if_only_gnt i=%0d got gnt=%b%b addr=%0d exp 10 addr=%0d", i,
                 if_gnt, ls_gnt, rom_addr, i);
      end
      if (i > 0) begin
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== rom_val(ADDR_W'(i - 1))) begin
          failures++;
          $display("FAIL if_only_resp i=%0d got v=%b d=%h exp v=1 d=%h", i, if_rvalid,
                   if_rdata, rom_val(ADDR_W'(i - 1)));
        end
      end
      step();
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== rom_val(10'd2) || ls_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL if_only_last got v=%b d=%h lsv=%b exp v=1 d=%h lsv=0", if_rvalid,
               if_rdata, ls_rvalid, rom_val(10'd2));
    end
    step();
  endtask

  task automatic test_alternate();
    do_reset();
    if_req = 1'b1; ls_req = 1'b1; if_addr = 10'd5; ls_addr = 10'd9;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, ls_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, {if_gnt, ls_gnt},
                 (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        checks++;
        if ((k % 2 == 1) ? (if_rvalid !== 1'b1 || if_rdata !== rom_val(10'd5) ||
                            ls_rvalid !== 1'b0)
                         : (ls_rvalid !== 1'b1 || ls_rdata !== rom_val(10'd9) ||
                            if_rvalid !== 1'b0)) begin
          failures++;
          $display("FAIL alt_resp k=%0d got ifv=%b ifd=%h lsv=%b lsd=%h", k, if_rvalid,
                   if_rdata, ls_rvalid, ls_rdata);
        end
      end
      step();
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== rom_val(10'd9) || if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL alt_last got lsv=%b lsd=%h ifv=%b exp lsv=1 lsd=%h ifv=0", ls_rvalid,
               ls_rdata, if_rvalid, rom_val(10'd9));
    end
    step();
  endtask

  task automatic test_ls_then_if();
    ls_req = 1'b1; ls_addr = 10'd17; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b01 || rom_addr !== 10'd17) begin
      failures++;
      $display("FAIL lsif_n got gnt=%b addr=%0d exp gnt=01 addr=17", {if_gnt, ls_gnt},
               rom_addr);
    end
    step();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 10'd4;
    @(negedge clk);
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== rom_val(10'd17) || if_rvalid !== 1'b0 ||
        if_gnt !== 1'b1 || rom_addr !== 10'd4) begin
      failures++;
      $display("FAIL lsif_n1 got lsv=%b lsd=%h ifv=%b ifg=%b addr=%0d", ls_rvalid,
               ls_rdata, if_rvalid, if_gnt, rom_addr);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== rom_val(10'd4) || ls_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL lsif_n2 got ifv=%b ifd=%h lsv=%b exp ifv=1 ifd=%h lsv=0", if_rvalid,
               if_rdata, ls_rvalid, rom_val(10'd4));
    end
    step();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 10'd6; ls_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b0 || rom_addr !== 10'd0) begin
      failures++;
      $display("FAIL midrst_gnt got gnt=%b addr=%0d exp gnt=0 addr=0", if_gnt, rom_addr);
    end
    step();
    reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_noresp got ifv=%b lsv=%b exp 0 0", if_rvalid, ls_rvalid);
    end
    step();
    if_req = 1'b1; ls_req = 1'b1; ls_addr = 10'd8;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b10 || rom_addr !== 10'd6) begin
      failures++;
      $display("FAIL midrst_tie got gnt=%b addr=%0d exp gnt=10 addr=6", {if_gnt, ls_gnt},
               rom_addr);
    end
    step();
    if_req = 1'b0; ls_req = 1'b0;
    step();
  endtask

  task automatic test_ls_drop();
    do_reset();
    if_req = 1'b1; ls_req = 1'b1; if_addr = 10'd11; ls_addr = 10'd12;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL drop_tie got=%b exp=10", {if_gnt, ls_gnt});
    end
    step();
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ls_gnt !== 1'b0 || ls_rvalid !== 1'b0 || ls_rdata !== 32'd0 ||
        if_rvalid !== 1'b1 || if_rdata !== rom_val(10'd11)) begin
      failures++;
      $display("FAIL drop_n1 got lsg=%b lsv=%b lsd=%h ifv=%b ifd=%h", ls_gnt, ls_rvalid,
               ls_rdata, if_rvalid, if_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0 || ls_gnt !== 1'b0) begin
      failures++;
      $display("FAIL drop_n2 got lsv=%b ifv=%b lsg=%b exp 0 0 0", ls_rvalid, if_rvalid,
               ls_gnt);
    end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; if_addr = '0; ls_addr = '0;
    test_reset();
    test_if_only();
    test_alternate();
    test_ls_then_if();
    test_reset_mid();
    test_ls_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
